// File: rtl/uart_time_cmd_rx.sv
// uart_time_cmd_rx
// Receives ASCII time-set commands ("T" HHMMSS CR) on a UART line and
// produces packed-BCD hour/minute/second values with a one-cycle load strobe.
// A 16x-oversampling 8N1 receiver feeds a command parser.
// The parser validates each digit and enforces an inter-byte timeout.
//
// Ports:
//   clk            16x-baud clock, all logic on its rising edge
//   rst            synchronous active-high reset
//   rx             UART serial input, idle high, asynchronous to clk
//   rx_byte        last correctly framed received byte
//   rx_byte_valid  one-cycle strobe, rx_byte updated
//   frame_err      one-cycle strobe, stop bit sampled low
//   set_hour       BCD hours 00-23
//   set_minute     BCD minutes 00-59
//   set_second     BCD seconds 00-59
//   set_valid      one-cycle strobe, set_* hold a new validated time
//   cmd_err        one-cycle strobe, command aborted
module uart_time_cmd_rx #(
  parameter int OVERSAMPLE     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic [7:0] set_hour,
  output logic [7:0] set_minute,
  output logic [7:0] set_second,
  output logic       set_valid,
  output logic       cmd_err
);

  localparam int TW = $clog2(OVERSAMPLE + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    CH_T      = 8'h54;
  localparam logic [7:0]    CH_CR     = 8'h0D;
  localparam logic [7:0]    CH_0      = 8'h30;
  localparam logic [7:0]    CH_9      = 8'h39;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state_reg;
  logic            sync1_reg, sync2_reg, rx_prev_reg;
  logic [TW-1:0]   tick_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      rx_prev_reg   <= 1'b1;
      rx_state_reg  <= RX_IDLE;
      tick_reg      <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      sync1_reg     <= rx;
      sync2_reg     <= sync1_reg;
      rx_prev_reg   <= sync2_reg;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          tick_reg <= '0;
          // The detection cycle itself is tick 0 of the start bit, so the
          // counter leaves this state already advanced to 1.
          if (rx_prev_reg && !sync2_reg) begin
            rx_state_reg <= RX_START;
            tick_reg     <= TW'(1);
          end
        end
        RX_START: begin
          if (tick_reg == HALF_LAST) begin
            tick_reg    <= '0;
            bit_idx_reg <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            rx_state_reg <= sync2_reg ? RX_IDLE : RX_DATA;
          end else begin
            tick_reg <= tick_reg + TW'(1);
          end
        end
        RX_DATA: begin
          if (tick_reg == BIT_LAST) begin
            tick_reg    <= '0;
            shift_reg   <= {sync2_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) rx_state_reg <= RX_STOP;
          end else begin
            tick_reg <= tick_reg + TW'(1);
          end
        end
        RX_STOP: begin
          if (tick_reg == BIT_LAST) begin
            tick_reg     <= '0;
            rx_state_reg <= RX_IDLE;
            if (sync2_reg) begin
              rx_byte       <= shift_reg;
              rx_byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            tick_reg <= tick_reg + TW'(1);
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ parser
  typedef enum logic [1:0] {P_IDLE, P_DIGIT, P_CR} p_state_t;

  p_state_t        p_state_reg;
  logic [2:0]      digit_idx_reg;
  logic [CW-1:0]   to_cnt_reg;
  logic [23:0]     digits;      // {h10, h1, m10, m1, s10, s1}
  logic [3:0]      digit_val;
  logic            digit_ok, digit_wr, byte_is_t;

  always_comb begin
    digit_val = rx_byte[3:0];   // equals byte - 0x30 for '0'..'9'
    byte_is_t = (rx_byte == CH_T);
    digit_ok  = (rx_byte >= CH_0) && (rx_byte <= CH_9);
    case (digit_idx_reg)
      3'd0:       if (digit_val > 4'd2) digit_ok = 1'b0;
      3'd1:       if (digits[23:20] == 4'd2 && digit_val > 4'd3) digit_ok = 1'b0;
      3'd2, 3'd4: if (digit_val > 4'd5) digit_ok = 1'b0;
      default:    ;
    endcase
    digit_wr = rx_byte_valid && (p_state_reg == P_DIGIT) && digit_ok;
  end

  // One shadow nibble per command digit position.
  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    logic [3:0] nib_reg;
    always_ff @(posedge clk) begin
      if (rst)
        nib_reg <= '0;
      else if (digit_wr && digit_idx_reg == 3'(gi))
        nib_reg <= digit_val;
    end
    assign digits[23 - 4*gi -: 4] = nib_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state_reg   <= P_IDLE;
      digit_idx_reg <= '0;
      to_cnt_reg    <= '0;
      set_hour      <= '0;
      set_minute    <= '0;
      set_second    <= '0;
      set_valid     <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      set_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (rx_byte_valid) begin
        // A byte always beats a coincident timeout.
        to_cnt_reg <= '0;
        case (p_state_reg)
          P_IDLE: begin
            if (byte_is_t) begin
              p_state_reg   <= P_DIGIT;
              digit_idx_reg <= '0;
            end
          end
          P_DIGIT: begin
            if (digit_ok) begin
              digit_idx_reg <= digit_idx_reg + 3'd1;
              if (digit_idx_reg == 3'd5) p_state_reg <= P_CR;
            end else begin
              cmd_err       <= 1'b1;
              digit_idx_reg <= '0;
              p_state_reg   <= byte_is_t ? P_DIGIT : P_IDLE;
            end
          end
          P_CR: begin
            digit_idx_reg <= '0;
            if (rx_byte == CH_CR) begin
              set_hour    <= digits[23:16];
              set_minute  <= digits[15:8];
              set_second  <= digits[7:0];
              set_valid   <= 1'b1;
              p_state_reg <= P_IDLE;
            end else begin
              cmd_err     <= 1'b1;
              p_state_reg <= byte_is_t ? P_DIGIT : P_IDLE;
            end
          end
          default: p_state_reg <= P_IDLE;
        endcase
      end else if (p_state_reg != P_IDLE) begin
        if (frame_err || to_cnt_reg == TO_LAST) begin
          cmd_err       <= 1'b1;
          digit_idx_reg <= '0;
          to_cnt_reg    <= '0;
          p_state_reg   <= P_IDLE;
        end else begin
          to_cnt_reg <= to_cnt_reg + CW'(1);
        end
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_time_cmd_rx.sv
// Testbench for uart_time_cmd_rx: directed scenarios followed by randomized
// commands. Expected events come from a string-level command model.
module tb_uart_time_cmd_rx;
  localparam int OS  = 16;
  localparam int TO  = 1000;
  localparam int LAT = 9*OS + OS/2 + 2;   // pin falling edge -> rx_byte_valid

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_valid, frame_err;
  logic [7:0] set_hour, set_minute, set_second;
  logic       set_valid, cmd_err;

  uart_time_cmd_rx #(.OVERSAMPLE(OS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .frame_err(frame_err),
    .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
    .set_valid(set_valid), .cmd_err(cmd_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic [31:0] ev_q[$];
  logic [7:0]  rcv_q[$];
  int fe_cnt = 0, err_cyc = -1, sv_cyc = -1, rbv_cyc = -1;
  int lat_bad = 0, both_cnt = 0, wide_cnt = 0;
  logic prev_rbv = 1'b0, prev_sv = 1'b0, prev_ce = 1'b0, prev_fe = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rx_byte_valid) begin rcv_q.push_back(rx_byte); rbv_cyc = cyc; end
    if (frame_err) fe_cnt++;
    if (set_valid) begin
      ev_q.push_back({8'h5E, set_hour, set_minute, set_second});
      sv_cyc = cyc;
      if (!prev_rbv) lat_bad++;
    end
    if (cmd_err) begin ev_q.push_back(32'hEE00_0000); err_cyc = cyc; end
    if (set_valid && cmd_err) both_cnt++;
    if ((set_valid && prev_sv) || (cmd_err && prev_ce) ||
        (rx_byte_valid && prev_rbv) || (frame_err && prev_fe)) wide_cnt++;
    prev_rbv = rx_byte_valid;
    prev_sv  = set_valid;
    prev_ce  = cmd_err;
    prev_fe  = frame_err;
  end

  // ------------------------------------------------------------------ model
  bit          m_active = 1'b0;
  logic [3:0]  m_dig[$];
  logic [23:0] m_hold = '0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_rx[$];

  function automatic bit digit_legal(input int n, input logic [7:0] b);
    int d, lim;
    if (b < 8'h30 || b > 8'h39) return 1'b0;
    d = int'(b) - 48;
    case (n)
      0:       lim = 2;
      1:       lim = (m_dig[0] == 4'd2) ? 3 : 9;
      2, 4:    lim = 5;
      default: lim = 9;
    endcase
    return d <= lim;
  endfunction

  function automatic void model_abort(input logic [7:0] b);
    exp_q.push_back(32'hEE00_0000);
    m_dig.delete();
    m_active = (b == 8'h54);
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit bad);
    logic [7:0] v;
    if (bad) begin
      if (m_active) model_abort(8'h00);
      return;
    end
    exp_rx.push_back(b);
    if (!m_active) begin
      if (b == 8'h54) begin m_active = 1'b1; m_dig.delete(); end
    end else if (m_dig.size() < 6) begin
      if (digit_legal(m_dig.size(), b)) begin
        v = b - 8'h30;
        m_dig.push_back(v[3:0]);
      end else model_abort(b);
    end else if (b == 8'h0D) begin
      m_hold = {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_dig[4], m_dig[5]};
      exp_q.push_back({8'h5E, m_hold});
      m_active = 1'b0;
      m_dig.delete();
    end else model_abort(b);
  endfunction

  // --------------------------------------------------------------- stimulus
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    rx = 1'b0; step(OS);
    for (int i = 0; i < 8; i++) begin rx = b[i]; step(OS); end
    rx = bad ? 1'b0 : 1'b1; step(OS);
    rx = 1'b1;
    if (bad) step(OS);
  endtask

  logic [7:0] tx_q[$];
  bit         tx_bad[$];
  int         starts_q[$];

  task automatic add_byte(input logic [7:0] b, input bit bad);
    tx_q.push_back(b);
    tx_bad.push_back(bad);
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) add_byte(s[i], 1'b0);
  endtask

  task automatic run_seq();
    starts_q.delete();
    for (int i = 0; i < tx_q.size(); i++) begin
      model_byte(tx_q[i], tx_bad[i]);
      starts_q.push_back(cyc);
      send_byte(tx_q[i], tx_bad[i]);
    end
    tx_q.delete();
    tx_bad.delete();
    step(4);
  endtask

  task automatic check_events(input string tag);
    check({tag, " event count"}, 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check({tag, " event"}, ev_q[i], exp_q[i]);
    check({tag, " rx count"}, 32'(rcv_q.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rcv_q.size(); i++)
      check({tag, " rx byte"}, 32'(rcv_q[i]), 32'(exp_rx[i]));
    check({tag, " set hold"}, {8'h00, set_hour, set_minute, set_second}, {8'h00, m_hold});
    ev_q.delete(); exp_q.delete(); rcv_q.delete(); exp_rx.delete();
  endtask

  function automatic logic [31:0] outs_low();
    return 32'({rx_byte, rx_byte_valid, frame_err, set_valid, cmd_err});
  endfunction

  logic [7:0] pool [8] = '{8'h30, 8'h33, 8'h35, 8'h39, 8'h54, 8'h0D, 8'h0A, 8'h78};

  initial begin
    int s, fe0, kind;
    step(5);
    check("reset set", {8'h00, set_hour, set_minute, set_second}, 32'h0);
    check("reset strobes", outs_low(), 32'h0);
    rst = 1'b0;
    step(5);

    // Out-of-range hour: error right after '4', rest ignored.
    add_str("T245959"); add_byte(8'h0D, 1'b0);
    run_seq();
    check("range err cycle", 32'(err_cyc), 32'(starts_q[2] + LAT + 1));
    check_events("range");

    // Valid command.
    add_str("T235959"); add_byte(8'h0D, 1'b0);
    run_seq();
    check("valid rbv cycle", 32'(rbv_cyc), 32'(starts_q[7] + LAT));
    check("valid sv cycle", 32'(sv_cyc), 32'(starts_q[7] + LAT + 1));
    check("valid time", {8'h00, set_hour, set_minute, set_second}, 32'h0023_5959);
    check_events("valid");

    // Restart on a second 'T'.
    add_str("T12T083000"); add_byte(8'h0D, 1'b0);
    run_seq();
    check("restart err cycle", 32'(err_cyc), 32'(starts_q[3] + LAT + 1));
    check("restart time", {8'h00, set_hour, set_minute, set_second}, 32'h0008_3000);
    check_events("restart");

    // Framing error mid-command.
    fe0 = fe_cnt;
    add_str("T1200"); add_byte(8'h30, 1'b1); add_str("00"); add_byte(8'h0D, 1'b0);
    run_seq();
    check("frame fe count", 32'(fe_cnt - fe0), 32'd1);
    check("frame err cycle", 32'(err_cyc), 32'(starts_q[5] + LAT + 1));
    check_events("frame");

    // Timeout: 1000 idle cycles after a byte aborts.
    add_str("T12");
    run_seq();
    s = starts_q[2] + LAT;
    while (cyc < s + TO + 3) step(1);
    exp_q.push_back(32'hEE00_0000);
    m_active = 1'b0;
    m_dig.delete();
    check("timeout cycle", 32'(err_cyc), 32'(s + TO + 1));
    check_events("timeout");

    // 999 idle cycles between bytes is still accepted.
    add_str("T12");
    run_seq();
    s = starts_q[2] + LAT;
    while (cyc < s + TO - LAT) step(1);
    add_str("0000"); add_byte(8'h0D, 1'b0);
    run_seq();
    check("gap next rbv", 32'(starts_q[0] + LAT - s), 32'(TO));
    check("gap time", {8'h00, set_hour, set_minute, set_second}, 32'h0012_0000);
    check_events("gap999");

    // Short low glitch is not a frame.
    fe0 = fe_cnt;
    rx = 1'b0; step(3); rx = 1'b1; step(200);
    check("glitch fe", 32'(fe_cnt - fe0), 32'd0);
    check_events("glitch");

    // Reset mid-command discards it.
    add_str("T1234");
    run_seq();
    check_events("pre reset");
    rst = 1'b1;
    step(3);
    check("in reset set", {8'h00, set_hour, set_minute, set_second}, 32'h0);
    check("in reset strobes", outs_low(), 32'h0);
    m_active = 1'b0; m_dig.delete(); m_hold = '0;
    step(5);
    rst = 1'b0;
    step(3);
    check("post reset set", {8'h00, set_hour, set_minute, set_second}, 32'h0);
    check("post reset strobes", outs_low(), 32'h0);
    add_str("56"); add_byte(8'h0D, 1'b0);
    run_seq();
    check_events("after reset");

    // Randomized commands.
    for (int r = 0; r < 12; r++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: add_str($sformatf("T%02d%02d%02d", $urandom_range(0, 23),
                             $urandom_range(0, 59), $urandom_range(0, 59)));
        1: begin
             add_byte(8'h54, 1'b0);
             for (int i = 0; i < 6; i++) add_byte(8'(8'h30 + $urandom_range(0, 9)), 1'b0);
           end
        2: begin
             add_byte(8'h54, 1'b0);
             for (int i = 0; i < 7; i++) add_byte(pool[$urandom_range(0, 7)], 1'b0);
           end
        3: begin
             add_byte(8'h0A, 1'b0); add_byte(8'h41, 1'b0);
             add_str($sformatf("T%02d%02d%02d", $urandom_range(0, 23),
                               $urandom_range(0, 59), $urandom_range(0, 59)));
           end
        default: begin
             add_str($sformatf("T%02d%02d", $urandom_range(0, 23), $urandom_range(0, 59)));
             add_byte(8'(8'h30 + $urandom_range(0, 5)), $urandom_range(0, 1) == 1);
             add_byte(8'(8'h30 + $urandom_range(0, 9)), 1'b0);
           end
      endcase
      add_byte(8'h0D, 1'b0);
      run_seq();
      check_events($sformatf("random %0d", r));
    end

    // Let any unfinished command time out.
    step(TO + 50);
    if (m_active) begin
      exp_q.push_back(32'hEE00_0000);
      m_active = 1'b0;
      m_dig.delete();
    end
    check_events("flush");

    check("strobe overlap", 32'(both_cnt), 32'd0);
    check("strobe width", 32'(wide_cnt), 32'd0);
    check("set_valid latency", 32'(lat_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
